// File: rtl/nios2_cpu_debug_host_scan.sv
// Virtual-JTAG scan initiator for the Nios II debug slave.
// Runs UIR, CDR, SDR, UDR and RTI per command; TCK is clk/2.
module nios2_cpu_debug_host_scan #(
    parameter int SR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    input  logic                cmd_skip_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_RESP
    } state_e;

    localparam int RW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
    localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);
    localparam logic [5:0] BIT_LAST = 6'(SR_WIDTH - 1);

    state_e state_q, state_d;
    logic                tck_q, tck_d;
    logic [5:0]          bit_q, bit_d;
    logic [RW-1:0]       rti_q, rti_d;
    logic [SR_WIDTH-1:0] sr_q, sr_d;
    logic [SR_WIDTH-1:0] cap_q, cap_d;
    logic                skip_q, skip_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] irout_q, irout_d;
    logic                tdi_q, tdi_d;
    logic                uir_q, uir_d;
    logic                cdr_q, cdr_d;
    logic                sdr_q, sdr_d;
    logic                udr_q, udr_d;
    logic                rti_f_q, rti_f_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;

    always_comb begin
        state_d = state_q;
        tck_d   = tck_q;
        bit_d   = bit_q;
        rti_d   = rti_q;
        sr_d    = sr_q;
        cap_d   = cap_q;
        skip_d  = skip_q;
        ir_d    = ir_q;
        irout_d = irout_q;
        tdi_d   = tdi_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_UIR;
                    ir_d    = cmd_ir;
                    sr_d    = cmd_data;
                    skip_d  = cmd_skip_dr;
                    cap_d   = '0;
                    tck_d   = 1'b0;
                    tdi_d   = 1'b0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (!tck_q) begin
                    // Rising TCK: slave outputs are sampled here.
                    tck_d = 1'b1;
                    if (state_q == S_UIR) begin
                        irout_d = vji_ir_out;
                    end
                    if (state_q == S_SDR) begin
                        cap_d = {vji_tdo, cap_q[SR_WIDTH-1:1]};
                    end
                end else begin
                    // Falling TCK ends the period; all slave inputs move here.
                    tck_d = 1'b0;
                    tdi_d = 1'b0;
                    unique case (state_q)
                        S_UIR: begin
                            state_d = skip_q ? S_RTI : S_CDR;
                            rti_d   = '0;
                        end
                        S_CDR: begin
                            state_d = S_SDR;
                            bit_d   = '0;
                            tdi_d   = sr_q[0];
                        end
                        S_SDR: begin
                            sr_d = sr_q >> 1;
                            if (bit_q == BIT_LAST) begin
                                state_d = S_UDR;
                            end else begin
                                bit_d = bit_q + 6'd1;
                                tdi_d = sr_d[0];
                            end
                        end
                        S_UDR: begin
                            state_d = S_RTI;
                            rti_d   = '0;
                        end
                        S_RTI: begin
                            if (rti_q == RTI_LAST) begin
                                state_d = S_RESP;
                            end else begin
                                rti_d = rti_q + 1'b1;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
        endcase

        uir_d       = (state_d == S_UIR);
        cdr_d       = (state_d == S_CDR);
        sdr_d       = (state_d == S_SDR);
        udr_d       = (state_d == S_UDR);
        rti_f_d     = (state_d == S_RTI);
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tck_q       <= 1'b0;
            bit_q       <= '0;
            rti_q       <= '0;
            sr_q        <= '0;
            cap_q       <= '0;
            skip_q      <= 1'b0;
            ir_q        <= '0;
            irout_q     <= '0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_f_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tck_q       <= tck_d;
            bit_q       <= bit_d;
            rti_q       <= rti_d;
            sr_q        <= sr_d;
            cap_q       <= cap_d;
            skip_q      <= skip_d;
            ir_q        <= ir_d;
            irout_q     <= irout_d;
            tdi_q       <= tdi_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            rti_f_q     <= rti_f_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = cap_q;
    assign rsp_ir_out = irout_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_q;
    assign vji_uir    = uir_q;
    assign vji_cdr    = cdr_q;
    assign vji_sdr    = sdr_q;
    assign vji_udr    = udr_q;
    assign vji_rti    = rti_f_q;

endmodule

// File: tb/tb_nios2_cpu_debug_host_scan.sv
// Bench for nios2_cpu_debug_host_scan: period-schedule model,
// shift-register slave model and directed literal checks.
module tb_nios2_cpu_debug_host_scan;

    localparam int SRW = 38;
    localparam int IRW = 2;
    localparam int RTI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir;
    logic [SRW-1:0] cmd_data;
    logic           cmd_skip_dr;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [SRW-1:0] rsp_data;
    logic [IRW-1:0] rsp_ir_out;
    logic           busy;
    logic           vji_tck;
    logic           vji_tdi;
    logic           vji_tdo;
    logic [IRW-1:0] vji_ir_in;
    logic [IRW-1:0] vji_ir_out;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    nios2_cpu_debug_host_scan #(
        .SR_WIDTH(SRW), .IR_WIDTH(IRW), .RTI_CYCLES(RTI)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_skip_dr(cmd_skip_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .busy(busy),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
        .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Slave: DR shifts in TDI at MSB on each rising TCK during SDR.
    logic [SRW-1:0] slave_q;
    logic [IRW-1:0] ir_out_drv;
    assign vji_tdo    = slave_q[0];
    assign vji_ir_out = ir_out_drv;
    always @(posedge vji_tck) begin
        if (vji_sdr) slave_q = {vji_tdi, slave_q[SRW-1:1]};
    end

    // Model: a command is a list of TCK periods, two clk cycles each.
    int             m_mode = 0;
    int             m_k = 0;
    int             m_len = 0;
    bit             m_started = 0;
    bit             m_skip = 0;
    logic [SRW-1:0] m_data = '0;
    logic [SRW-1:0] m_exp_data = '0;
    logic [SRW-1:0] m_last_data = '0;
    logic [IRW-1:0] m_exp_ir = '0;
    logic [IRW-1:0] m_last_ir = '0;
    logic [IRW-1:0] m_ir_in = '0;

    function automatic int kind(input int p, input bit skip);
        if (p == 0) return 1;
        if (skip) return 5;
        if (p == 1) return 2;
        if (p < 2 + SRW) return 3;
        if (p == 2 + SRW) return 4;
        return 5;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_mode = 0;
            m_ir_in = '0;
            m_last_data = '0;
            m_last_ir = '0;
        end else begin
            case (m_mode)
                0: if (cmd_valid) begin
                    m_mode = 1;
                    m_k = 0;
                    m_skip = cmd_skip_dr;
                    m_data = cmd_data;
                    m_ir_in = cmd_ir;
                    m_exp_data = cmd_skip_dr ? '0 : slave_q;
                    m_exp_ir = ir_out_drv;
                    m_len = cmd_skip_dr ? 1 + RTI : 3 + SRW + RTI;
                end
                1: begin
                    m_k++;
                    if (m_k == 2 * m_len) begin
                        m_mode = 2;
                        m_last_data = m_exp_data;
                        m_last_ir = m_exp_ir;
                    end
                end
                default: if (rsp_ready) m_mode = 0;
            endcase
        end
        m_started = 1;
    end

    always @(negedge clk) begin : cmp
        logic [9:0] e;
        logic [4:0] fl;
        logic       t;
        int         kd;
        if (m_started) begin
            case (m_mode)
                0: e = 10'b1000000000;
                1: begin
                    kd = kind(m_k / 2, m_skip);
                    fl = 5'b10000 >> (kd - 1);
                    t = (kd == 3) ? m_data[m_k / 2 - 2] : 1'b0;
                    e = {1'b0, 1'b1, 1'b0, 1'(m_k % 2), fl, t};
                end
                default: e = 10'b0110000000;
            endcase
            check("cycle_ctl", {cmd_ready, busy, rsp_valid, vji_tck,
                  vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi}, e);
            check("cycle_ir_in", vji_ir_in, m_ir_in);
            if (m_mode != 1) begin
                check("cycle_rsp_data", rsp_data, m_last_data);
                check("cycle_rsp_ir", rsp_ir_out, m_last_ir);
            end
        end
    end

    // Period and hold monitor.
    int         tck_rises = 0, uir_hi = 0, udr_hi = 0, sdr_cyc = 0;
    int         hold_viol = 0;
    logic       prev_tck = 1'b0;
    logic [5:0] prev_sig = '0;
    always @(negedge clk) begin
        if (vji_tck && !prev_tck) begin
            tck_rises++;
            if ({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi}
                !== prev_sig) hold_viol++;
        end
        if (vji_uir && vji_tck) uir_hi++;
        if (vji_udr && vji_tck) udr_hi++;
        if (vji_sdr) sdr_cyc++;
        prev_tck = vji_tck;
        prev_sig = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi};
    end

    task automatic clr_mon();
        tck_rises = 0;
        uir_hi = 0;
        udr_hi = 0;
        sdr_cyc = 0;
        hold_viol = 0;
    endtask

    // Presents a command; returns #1 after the accepting edge.
    task automatic send(input logic [IRW-1:0] ir, input logic [SRW-1:0] d,
                        input logic s);
        int w;
        cmd_ir = ir;
        cmd_data = d;
        cmd_skip_dr = s;
        cmd_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!rsp_valid && n < 300);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int             lat;
        int             stall_bad;
        logic [SRW-1:0] held;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_ir = '0;
        cmd_data = '0;
        cmd_skip_dr = 1'b0;
        ir_out_drv = '0;
        slave_q = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {cmd_ready, busy, rsp_valid, vji_tck, vji_uir,
              vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi}, 10'b1000000000);
        check("rst_data", rsp_data, 38'h0);
        check("rst_ir", {rsp_ir_out, vji_ir_in}, 4'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        slave_q = 38'h00_DEAD_BEEF;
        ir_out_drv = 2'b10;
        clr_mon();
        send(2'b01, 38'h2A_5555_5555, 1'b0);
        wait_rsp(lat);
        check("full_latency", lat, 86);
        check("full_data", rsp_data, 38'h00_DEAD_BEEF);
        check("full_ir_out", rsp_ir_out, 2'b10);
        check("full_ir_in", vji_ir_in, 2'b01);
        check("full_slave", slave_q, 38'h2A_5555_5555);
        check("full_uir_periods", uir_hi, 1);
        check("full_udr_periods", udr_hi, 1);
        check("full_tck_rises", tck_rises, 43);
        check("full_hold", hold_viol, 0);
        ack();

        ir_out_drv = 2'b01;
        clr_mon();
        send(2'b11, 38'h3F_FFFF_FFFF, 1'b1);
        wait_rsp(lat);
        check("ir_latency", lat, 6);
        check("ir_data", rsp_data, 38'h0);
        check("ir_sdr_cycles", sdr_cyc, 0);
        check("ir_ir_out", rsp_ir_out, 2'b01);
        check("ir_ir_in", vji_ir_in, 2'b11);
        check("ir_tck_rises", tck_rises, 3);
        ack();

        ir_out_drv = 2'b10;
        send(2'b10, 38'h15_AAAA_0F0F, 1'b0);
        cmd_ir = 2'b01;
        cmd_data = 38'h0C_3C3C_A5A5;
        cmd_skip_dr = 1'b0;
        cmd_valid = 1'b1;
        wait_rsp(lat);
        check("b2b1_latency", lat, 86);
        held = rsp_data;
        stall_bad = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_data !== held || !rsp_valid || vji_tck) stall_bad++;
        end
        check("stall_stable", stall_bad, 0);
        check("stall_data", rsp_data, 38'h2A_5555_5555);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("b2b_ready_after_hs", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_accepted", {busy, cmd_ready, vji_uir}, 3'b101);
        wait_rsp(lat);
        check("b2b2_latency", lat, 86);
        check("b2b2_data", rsp_data, 38'h15_AAAA_0F0F);
        check("b2b2_slave", slave_q, 38'h0C_3C3C_A5A5);
        ack();

        slave_q = 38'h12_3456_789A;
        send(2'b01, 38'h33_CCCC_3333, 1'b0);
        repeat (38) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("mid_in_sdr", vji_sdr, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out", {vji_sdr, vji_tck, rsp_valid, cmd_ready},
              4'b0001);
        @(posedge clk);
        #1 reset_n = 1'b1;
        slave_q = 38'h21_0F0F_F0F0;
        ir_out_drv = 2'b11;
        send(2'b10, 38'h0A_1234_5678, 1'b0);
        wait_rsp(lat);
        check("post_latency", lat, 86);
        check("post_data", rsp_data, 38'h21_0F0F_F0F0);
        check("post_ir_out", rsp_ir_out, 2'b11);
        check("post_slave", slave_q, 38'h0A_1234_5678);
        ack();
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
